uart_tx: RTL and testbench
==========================

# uart_tx

Packet transmitter for the RS-232 link; the transmit-side counterpart of the receive path. Accepts a 4-byte packet (tpd0..tpd3) on a single request pulse and serializes it on txsd as four back-to-back 8N1 frames, tpd0 first, LSB first. Bit timing comes from the shared oversample tick txck, the same tick the receiver uses, so a tx→rx loopback reproduces rpd0..rpd3 exactly.

## Interface
- OVS, 16: txck ticks per bit period (≥2)
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- txck  in  1  oversample tick, one clk wide, OVS per bit
- snd_req  in  1  start-of-packet request, sampled every clk
- tpd0, tpd1, tpd2, tpd3  in  8 each  packet bytes, sampled only on acceptance
- txsd  out  1  serial data, idle high
- txbusy  out  1  packet in progress
- snd_done  out  1  one-clk pulse, packet fully sent

## Operation
- Reset (rst=0, asynchronous): txsd=1, txbusy=0, snd_done=0, all counters 0, byte index 0, FSMs idle.
- Acceptance: snd_req=1 while txbusy=0 → latch tpd0..tpd3 into an internal 32-bit shadow; txbusy=1 from the next edge. snd_req while txbusy=1 is ignored, with no queueing. Later tpd changes do not affect the packet in flight.
- Serializer FSM states:
  - IDLE: txsd=1.
  - START: txsd=0.
  - DATA: txsd = shift[0]; bit_idx 0..7.
  - STOP: txsd=1.
- Serializer transitions:
  - IDLE→START on the first txck after a byte is loaded.
  - Each state holds for OVS txck ticks, counted by tick_cnt 0..OVS-1, which wraps to 0 on state advance.
  - START→DATA after OVS ticks. In DATA, after each OVS ticks, shift right; bit_idx 7→STOP. STOP→IDLE after OVS ticks, and the serializer pulses byte_done.
- Sequencer FSM states:
  - S_IDLE: wait for acceptance.
  - S_LOAD: present byte[idx] to the serializer.
  - S_WAIT: wait for byte_done, then idx+1.
  - After idx=3 completes: snd_done=1 for one clk, txbusy=0 in the same edge, return to S_IDLE, idx=0.
- Back-to-back bytes: the next start bit begins on the first txck after the previous stop bit ends. No extra idle bits inside a packet.
- A new request is accepted in the cycle after snd_done at the earliest, because txbusy is already 0.
- txck absent: all counters hold; txsd holds its current level indefinitely.
- Width rules: tick_cnt is clog2(OVS) bits; bit_idx is 3 bits; byte idx is 2 bits.

## Timing
- Acceptance edge k → txbusy=1 at k+1. txsd falls on the edge where the first txck after k+1 is sampled.
- Packet length is exactly 40·OVS txck ticks from the txsd fall to the end of the last stop bit.
- snd_done is asserted on the edge that ends the byte-3 stop bit (the OVS-th STOP tick). txsd is already 1 and remains 1.
- All outputs are registered; no combinational path from inputs to txsd, txbusy or snd_done.
- Reset mid-frame: txsd returns to 1 asynchronously and the partial frame is truncated. No snd_done is produced for the aborted packet.
- snd_req arriving on the same edge as snd_done is ignored; txbusy is still 1 at sampling.

## Structure
- Shared package uart_pkg:
  - OVS default
  - frame constants: DATA_BITS=8, NBYTE=4
  - serializer state encoding (IDLE/START/DATA/STOP)
  - sequencer state encoding (S_IDLE/S_LOAD/S_WAIT)
- Sub-module tx232_ser: single-byte serializer.
  - Inputs: clk, rst, txck, txen (load strobe), txpd[7:0].
  - Outputs: txsd, byte_done.
- Top uart_tx holds the sequencer and the shadow register, mirroring the pd/rcv split of the receive side.

## Test plan
- Reset: hold rst=0 with txck running → txsd=1, txbusy=0, snd_done=0 throughout; release → no activity without snd_req.
- Basic packet, OVS=16: tpd0..3 = 0x55, 0xA3, 0x00, 0xFF, one snd_req.
  - Required: txsd decoded at mid-bit = four 8N1 frames in order.
  - Required: 640 txck ticks from the first fall to the end of the last stop bit.
  - Required: exactly one snd_done pulse; txbusy drops on the same edge.
- Busy rejection: second snd_req with 0x11223344 mid-packet → the original bytes are sent unchanged; only one snd_done.
- Reset mid-packet: assert rst during the byte-1 data bits → txsd=1 immediately, no snd_done. A fresh request with 0xDE, 0xAD, 0xBE, 0xEF afterwards transmits correctly.
- txck stall: gate txck off for 1000 clks during byte 2 → txsd frozen; frame completes correctly once txck resumes.
- Loopback: txsd→uart_rx rxsd, shared txck/rxck, 0x12, 0x34, 0x56, 0x78 → rcv_done, with rpd0..3 = 0x12, 0x34, 0x56, 0x78.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the RS-232 transmit path: oversample default, frame
// geometry and the state encodings of the serializer and packet sequencer.
package uart_pkg;

    localparam int OVS_DEF   = 16;
    localparam int DATA_BITS = 8;
    localparam int NBYTE     = 4;

    localparam logic [1:0] SER_IDLE  = 2'd0;
    localparam logic [1:0] SER_START = 2'd1;
    localparam logic [1:0] SER_DATA  = 2'd2;
    localparam logic [1:0] SER_STOP  = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

endpackage

// File: rtl/tx232_ser.sv
// Single-byte 8N1 serializer timed by the shared oversample tick txck.
// byte_done marks the tick that ends the stop bit so the next byte can follow gap-free.
module tx232_ser
    import uart_pkg::*;
#(
    parameter int OVS = OVS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txck,
    input  logic       txen,
    input  logic [7:0] txpd,
    output logic       txsd,
    output logic       byte_done
);

    localparam int             TW        = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0]  TICK_ONE  = TW'(1);
    localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          pend_q, pend_d;
    logic          txsd_q, txsd_d;
    logic          tick_last_s;

    assign tick_last_s = txck && (tick_cnt_q == TICK_LAST);
    assign byte_done   = (state_q == SER_STOP) && tick_last_s;
    assign txsd        = txsd_q;

    // Next-state logic; the tick that drops txsd counts as the first start-bit tick.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pend_d     = pend_q;
        txsd_d     = txsd_q;
        case (state_q)
            SER_IDLE: begin
                txsd_d = 1'b1;
                if (pend_q && txck) begin
                    state_d    = SER_START;
                    tick_cnt_d = TICK_ONE;
                    pend_d     = 1'b0;
                    txsd_d     = 1'b0;
                end else if (txen) begin
                    shift_d = txpd;
                    pend_d  = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
            end
            SER_START: begin
                if (tick_last_s) begin
                    state_d    = SER_DATA;
                    tick_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    txsd_d     = shift_q[0];
                end else if (txck) begin
                    tick_cnt_d = tick_cnt_q + TICK_ONE;
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            SER_DATA: begin
                if (tick_last_s) begin
                    tick_cnt_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = SER_STOP;
                        txsd_d  = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        txsd_d    = shift_q[1];
                    end
                end else if (txck) begin
                    tick_cnt_d = tick_cnt_q + TICK_ONE;
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            SER_STOP: begin
                if (tick_last_s) begin
                    state_d    = SER_IDLE;
                    tick_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                end else if (txck) begin
                    tick_cnt_d = tick_cnt_q + TICK_ONE;
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            default: begin
                state_d    = SER_IDLE;
                tick_cnt_d = '0;
                bit_idx_d  = 3'd0;
                pend_d     = 1'b0;
                txsd_d     = 1'b1;
            end
        endcase
    end

    // State registers; reset forces the line idle and discards any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SER_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            pend_q     <= 1'b0;
            txsd_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            pend_q     <= pend_d;
            txsd_q     <= txsd_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Packet transmitter: latches a 4-byte packet on snd_req and feeds it byte by
// byte to tx232_ser, tpd0 first; snd_done pulses on the edge ending the last stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVS = OVS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txck,
    input  logic       snd_req,
    input  logic [7:0] tpd0,
    input  logic [7:0] tpd1,
    input  logic [7:0] tpd2,
    input  logic [7:0] tpd3,
    output logic       txsd,
    output logic       txbusy,
    output logic       snd_done
);

    localparam logic [1:0] IDX_LAST = 2'(NBYTE - 1);

    logic [1:0]  seq_q, seq_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] shadow_q, shadow_d;
    logic        txbusy_q, txbusy_d;
    logic        snd_done_q, snd_done_d;
    logic        txen_s;
    logic        byte_done_s;
    logic [7:0]  txpd_s;

    assign txen_s   = (seq_q == S_LOAD);
    assign txpd_s   = shadow_q[{idx_q, 3'b000} +: 8];
    assign txbusy   = txbusy_q;
    assign snd_done = snd_done_q;

    tx232_ser #(.OVS(OVS)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .txck      (txck),
        .txen      (txen_s),
        .txpd      (txpd_s),
        .txsd      (txsd),
        .byte_done (byte_done_s)
    );

    // Sequencer next-state; requests are only looked at in S_IDLE, so busy requests vanish.
    always_comb begin
        seq_d      = seq_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        txbusy_d   = txbusy_q;
        snd_done_d = 1'b0;
        case (seq_q)
            S_IDLE: begin
                if (snd_req) begin
                    shadow_d = {tpd3, tpd2, tpd1, tpd0};
                    idx_d    = 2'd0;
                    txbusy_d = 1'b1;
                    seq_d    = S_LOAD;
                end else begin
                    txbusy_d = 1'b0;
                end
            end
            S_LOAD: begin
                seq_d = S_WAIT;
            end
            S_WAIT: begin
                if (byte_done_s && (idx_q == IDX_LAST)) begin
                    snd_done_d = 1'b1;
                    txbusy_d   = 1'b0;
                    idx_d      = 2'd0;
                    seq_d      = S_IDLE;
                end else if (byte_done_s) begin
                    idx_d = idx_q + 2'd1;
                    seq_d = S_LOAD;
                end else begin
                    seq_d = S_WAIT;
                end
            end
            default: begin
                seq_d    = S_IDLE;
                idx_d    = 2'd0;
                txbusy_d = 1'b0;
            end
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q      <= S_IDLE;
            idx_q      <= 2'd0;
            shadow_q   <= 32'd0;
            txbusy_q   <= 1'b0;
            snd_done_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            txbusy_q   <= txbusy_d;
            snd_done_q <= snd_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes expected packets, a monitor
// decodes txsd against txck ticks and checks frames, gap-free framing and snd_done.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       txck = 1'b0;
    logic       snd_req = 1'b0;
    logic [7:0] tpd0 = 8'h00, tpd1 = 8'h00, tpd2 = 8'h00, tpd3 = 8'h00;
    logic       txsd, txbusy, snd_done;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          done_cnt = 0;
    logic        txck_en = 1'b1;
    int          div = 0;
    logic [31:0] exp_q[$];

    int   consumed = 0;
    logic pend_tick = 1'b0;
    logic mon_abort = 1'b0;
    int   mon_steps = 0;

    uart_tx #(.OVS(OVS)) dut (
        .clk      (clk),
        .rst      (rst),
        .txck     (txck),
        .snd_req  (snd_req),
        .tpd0     (tpd0),
        .tpd1     (tpd1),
        .tpd2     (tpd2),
        .tpd3     (tpd3),
        .txsd     (txsd),
        .txbusy   (txbusy),
        .snd_done (snd_done)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            div  = (div + 1) % 4;
            txck = txck_en && (div == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (snd_done === 1'b1) done_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    task automatic fail_now(input string name);
        chk_cnt++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // one negedge of the monitor: consumed = txck ticks already sampled by the DUT
    task automatic mstep();
        @(negedge clk);
        if (rst !== 1'b1) mon_abort = 1'b1;
        consumed += int'(pend_tick);
        pend_tick = txck;
        mon_steps++;
        if (mon_steps > 20000 && !mon_abort) begin
            fail_now("monitor_timeout");
            mon_abort = 1'b1;
        end
    endtask

    task automatic madvance(input int target);
        while (!mon_abort && consumed < target) mstep();
    endtask

    initial begin : monitor
        logic [31:0] pkt;
        logic [7:0]  got;
        logic        startb, stopb;
        forever begin
            wait (exp_q.size() > 0);
            pkt       = exp_q[0];
            mon_abort = 1'b0;
            mon_steps = 0;
            while (!mon_abort && txsd !== 1'b0) mstep();
            consumed = 1;
            for (int f = 0; f < 4 && !mon_abort; f++) begin
                madvance(OVS / 2);
                startb = txsd;
                for (int b = 1; b <= 8; b++) begin
                    madvance(b * OVS + OVS / 2);
                    got[b-1] = txsd;
                end
                madvance(9 * OVS + OVS / 2);
                stopb = txsd;
                madvance(10 * OVS);
                if (!mon_abort) begin
                    check($sformatf("start_bit%0d", f), {31'd0, startb}, 32'd0);
                    check($sformatf("byte%0d", f), {24'd0, got}, {24'd0, pkt[f*8 +: 8]});
                    check($sformatf("stop_bit%0d", f), {31'd0, stopb}, 32'd1);
                    if (f == 3) begin
                        check("done_at_last_stop", {31'd0, snd_done}, 32'd1);
                        check("busy_drop_with_done", {31'd0, txbusy}, 32'd0);
                        check("line_idle_after_pkt", {31'd0, txsd}, 32'd1);
                    end else begin
                        madvance(10 * OVS + 1);
                        if (!mon_abort) check($sformatf("gapless_start%0d", f + 1), {31'd0, txsd}, 32'd0);
                        consumed = 1;
                    end
                end
            end
            if (mon_abort) wait (rst === 1'b1);
            void'(exp_q.pop_front());
        end
    end

    task automatic send(input logic [7:0] b0, b1, b2, b3, input bit accept);
        @(negedge clk);
        tpd0 = b0; tpd1 = b1; tpd2 = b2; tpd3 = b3;
        snd_req = 1'b1;
        @(negedge clk);
        snd_req = 1'b0;
        tpd0 = ~b0; tpd1 = ~b1; tpd2 = ~b2; tpd3 = ~b3;
        if (accept) exp_q.push_back({b3, b2, b1, b0});
        check("busy_after_req", {31'd0, txbusy}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (txbusy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) fail_now(name);
    endtask

    initial begin
        int   d0;
        logic frozen;
        int   n;
        // reset held with txck running
        for (int i = 0; i < 5; i++) begin
            repeat (4) @(negedge clk);
            check("rst_txsd", {31'd0, txsd}, 32'd1);
            check("rst_busy", {31'd0, txbusy}, 32'd0);
            check("rst_done", {31'd0, snd_done}, 32'd0);
        end
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_txsd", {31'd0, txsd}, 32'd1);
        check("idle_busy", {31'd0, txbusy}, 32'd0);
        check("idle_no_done", done_cnt, 32'd0);

        // basic packet
        send(8'h55, 8'hA3, 8'h00, 8'hFF, 1'b1);
        wait_idle("basic_idle");
        repeat (10) @(negedge clk);
        check("basic_done_cnt", done_cnt, 32'd1);

        // request while busy is dropped
        send(8'h01, 8'h80, 8'h7E, 8'hC3, 1'b1);
        repeat (1500) @(negedge clk);
        send(8'h44, 8'h33, 8'h22, 8'h11, 1'b0);
        wait_idle("busy_idle");
        repeat (200) @(negedge clk);
        check("busy_done_cnt", done_cnt, 32'd2);
        check("busy_no_queue", {31'd0, txbusy}, 32'd0);

        // reset during byte-1 data bits (0xC1 bits 1..5 are 0)
        d0 = done_cnt;
        send(8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b1);
        repeat (800) @(negedge clk);
        check("pre_rst_txsd_low", {31'd0, txsd}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check("midrst_txsd", {31'd0, txsd}, 32'd1);
        check("midrst_busy", {31'd0, txbusy}, 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3000) @(negedge clk);
        check("midrst_no_done", done_cnt, d0);
        check("midrst_line_idle", {31'd0, txsd}, 32'd1);
        send(8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b1);
        wait_idle("post_rst_idle");
        repeat (10) @(negedge clk);
        check("post_rst_done_cnt", done_cnt, d0 + 1);

        // txck stall during byte 2
        d0 = done_cnt;
        send(8'h5A, 8'h3C, 8'h96, 8'h0F, 1'b1);
        repeat (1400) @(negedge clk);
        txck_en = 1'b0;
        @(negedge clk);
        frozen = txsd;
        for (int i = 0; i < 10; i++) begin
            repeat (100) @(negedge clk);
            check("stall_frozen", {31'd0, txsd}, {31'd0, frozen});
        end
        txck_en = 1'b1;
        wait_idle("stall_idle");
        repeat (10) @(negedge clk);
        check("stall_done_cnt", done_cnt, d0 + 1);

        // loopback bytes, with snd_req held through snd_done: accepted the cycle after
        d0 = done_cnt;
        @(negedge clk);
        tpd0 = 8'h12; tpd1 = 8'h34; tpd2 = 8'h56; tpd3 = 8'h78;
        snd_req = 1'b1;
        @(negedge clk);
        exp_q.push_back(32'h78563412);
        check("hold_busy", {31'd0, txbusy}, 32'd1);
        tpd0 = 8'hA1; tpd1 = 8'hB2; tpd2 = 8'hC3; tpd3 = 8'hD4;
        n = 0;
        while (snd_done !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            fail_now("hold_done_wait");
        end else begin
            exp_q.push_back(32'hD4C3B2A1);
            check("hold_busy_low_at_done", {31'd0, txbusy}, 32'd0);
            @(negedge clk);
            check("hold_reaccept", {31'd0, txbusy}, 32'd1);
        end
        snd_req = 1'b0;
        wait_idle("hold_idle");
        repeat (10) @(negedge clk);
        check("hold_done_cnt", done_cnt, d0 + 2);

        n = 0;
        while (exp_q.size() > 0 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10000) fail_now("scoreboard_drain");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
